// File: rtl/wfq_tag_sorter.sv
// Sorted tag store for a WFQ scheduler: single-cycle sorted insert, pop of the smallest tag.
// Optional macro WFQ_TAG_WRAP_CMP_EN selects serial-number (wrap-aware) tag comparison.
module wfq_tag_sorter #(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ins_valid,
    input  logic [N-1:0]  ins_ftime,
    input  logic [N-4:0]  ins_flow_id,
    input  logic          deq_req,
    output logic          deq_valid,
    output logic [N-1:0]  deq_ftime,
    output logic [N-4:0]  deq_flow_id,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          ins_drop
);

    typedef struct packed {
        logic         valid;
        logic [N-1:0] ftime;
        logic [N-4:0] flow;
    } entry_t;

    entry_t slot [DEPTH];
    entry_t view [DEPTH];
    entry_t nxt  [DEPTH];
    entry_t ins_e;

    logic [DEPTH-1:0] le;
    logic [DEPTH-1:0] prev_le;
    logic             deq_fire;
    logic             ins_acc;
    logic [CW-1:0]    cnt_nxt;

    // True when stored tag a sorts at or before new tag b (ties keep arrival order).
    function automatic logic tag_le(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] d;
`ifdef WFQ_TAG_WRAP_CMP_EN
        d = b - a;
        return ~d[N-1];
`else
        d = '0;
        return ~(b < a) | d[0];
`endif
    endfunction

    assign deq_fire = deq_req && (count != '0);
    assign ins_acc  = ins_valid && (!full || deq_fire);
    assign cnt_nxt  = count + CW'(ins_acc) - CW'(deq_fire);
    assign ins_e    = '{valid: 1'b1, ftime: ins_ftime, flow: ins_flow_id};

    // Storage as seen after an optional head pop; the insert is sorted into this view.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++)
            view[i] = deq_fire ? slot[i+1] : slot[i];
        view[DEPTH-1] = deq_fire ? entry_t'('0) : slot[DEPTH-1];
    end

    always_comb begin
        le      = '0;
        prev_le = '0;
        for (int i = 0; i < DEPTH; i++)
            le[i] = view[i].valid && tag_le(view[i].ftime, ins_ftime);
        prev_le[0] = 1'b1;
        for (int i = 1; i < DEPTH; i++)
            prev_le[i] = le[i-1];
    end

    // le is a prefix mask because storage is sorted; the first clear bit is the insert slot.
    always_comb begin
        nxt[0] = view[0];
        if (ins_acc && !le[0])
            nxt[0] = ins_e;
        for (int i = 1; i < DEPTH; i++) begin
            nxt[i] = view[i];
            if (ins_acc && !le[i])
                nxt[i] = prev_le[i] ? ins_e : view[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                slot[i] <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            deq_valid   <= 1'b0;
            ins_drop    <= 1'b0;
            deq_ftime   <= '0;
            deq_flow_id <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                slot[i] <= nxt[i];
            count     <= cnt_nxt;
            empty     <= (cnt_nxt == '0);
            full      <= (cnt_nxt == CW'(DEPTH));
            deq_valid <= deq_fire;
            ins_drop  <= ins_valid && full && !deq_fire;
            if (deq_fire) begin
                deq_ftime   <= slot[0].ftime;
                deq_flow_id <= slot[0].flow;
            end
        end
    end

endmodule

// File: tb/tb_wfq_tag_sorter.sv
// Directed bench for wfq_tag_sorter: expected pops are queued at request time, checked on deq_valid.
module tb_wfq_tag_sorter;
    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ins_valid = 1'b0;
    logic [N-1:0]  ins_ftime = '0;
    logic [N-4:0]  ins_flow_id = '0;
    logic          deq_req = 1'b0;
    logic          deq_valid;
    logic [N-1:0]  deq_ftime;
    logic [N-4:0]  deq_flow_id;
    logic [CW-1:0] count;
    logic          empty, full, ins_drop;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q [$];

    wfq_tag_sorter #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ftime(ins_ftime), .ins_flow_id(ins_flow_id),
        .deq_req(deq_req), .deq_valid(deq_valid), .deq_ftime(deq_ftime),
        .deq_flow_id(deq_flow_id), .count(count), .empty(empty), .full(full),
        .ins_drop(ins_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [N-1:0] ft, input logic [N-4:0] fl);
        ins_valid = 1'b1; ins_ftime = ft; ins_flow_id = fl;
        tick();
        ins_valid = 1'b0;
    endtask

    task automatic deq(input logic [N-1:0] ft, input logic [N-4:0] fl);
        exp_q.push_back({ft, 3'b000, fl});
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        chk("deq_latency", 32'(deq_valid), 32'd1);
    endtask

    // Scoreboard side: every deq_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (deq_valid) begin
            if (exp_q.size() == 0)
                chk("stray_deq_valid", 32'd1, 32'd0);
            else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("deq_ftime", 32'(deq_ftime), 32'(e[31:16]));
                chk("deq_flow", 32'(deq_flow_id), 32'(e[12:0]));
            end
        end
    end

    initial begin
        logic [N-1:0] fill_t [8];
        fill_t = '{16'd30, 16'd80, 16'd50, 16'd70, 16'd60, 16'd20, 16'd40, 16'd10};

        repeat (3) tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_ins_drop", 32'(ins_drop), 32'd0);
        chk("rst_deq_ftime", 32'(deq_ftime), 32'd0);
        chk("rst_deq_flow", 32'(deq_flow_id), 32'd0);
        rst = 1'b0;
        tick();

        // basic sort
        ins(16'd40, 13'd1); ins(16'd10, 13'd2); ins(16'd25, 13'd3);
        chk("count_3", 32'(count), 32'd3);
        deq(16'd10, 13'd2); deq(16'd25, 13'd3); deq(16'd40, 13'd1);
        chk("empty_after_drain", 32'(empty), 32'd1);

        // equal tags keep arrival order
        ins(16'd20, 13'd1); ins(16'd20, 13'd5);
        deq(16'd20, 13'd1); deq(16'd20, 13'd5);

        // fill, overflow drop, then insert with simultaneous pop
        for (int i = 0; i < 8; i++) ins(fill_t[i], 13'(i + 1));
        chk("full_8", 32'(full), 32'd1);
        chk("count_8", 32'(count), 32'd8);
        ins(16'd200, 13'd9);
        chk("ins_drop_pulse", 32'(ins_drop), 32'd1);
        chk("count_after_drop", 32'(count), 32'd8);
        tick();
        chk("ins_drop_clear", 32'(ins_drop), 32'd0);
        exp_q.push_back({16'd10, 3'b000, 13'd8});
        ins_valid = 1'b1; ins_ftime = 16'd5; ins_flow_id = 13'd10; deq_req = 1'b1;
        tick();
        ins_valid = 1'b0; deq_req = 1'b0;
        chk("swap_deq_valid", 32'(deq_valid), 32'd1);
        chk("swap_count", 32'(count), 32'd8);
        chk("swap_no_drop", 32'(ins_drop), 32'd0);
        deq(16'd5, 13'd10); deq(16'd20, 13'd6); deq(16'd30, 13'd1); deq(16'd40, 13'd7);
        deq(16'd50, 13'd3); deq(16'd60, 13'd5); deq(16'd70, 13'd4); deq(16'd80, 13'd2);
        chk("empty_after_fill_drain", 32'(empty), 32'd1);

        // pop request on empty is ignored, outputs hold
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        chk("empty_deq_ignored", 32'(deq_valid), 32'd0);
        chk("deq_ftime_hold", 32'(deq_ftime), 32'd80);
        chk("count_still_0", 32'(count), 32'd0);

        // insert + pop on empty: no bypass
        ins_valid = 1'b1; ins_ftime = 16'd7; ins_flow_id = 13'd3; deq_req = 1'b1;
        tick();
        ins_valid = 1'b0; deq_req = 1'b0;
        chk("nobypass_deq_valid", 32'(deq_valid), 32'd0);
        chk("nobypass_count", 32'(count), 32'd1);
        deq(16'd7, 13'd3);

        // wrap-around ordering
        ins(16'hFFF0, 13'd1); ins(16'h0010, 13'd2);
`ifdef WFQ_TAG_WRAP_CMP_EN
        deq(16'hFFF0, 13'd1); deq(16'h0010, 13'd2);
`else
        deq(16'h0010, 13'd2); deq(16'hFFF0, 13'd1);
`endif

        // reset mid-operation
        for (int i = 0; i < 5; i++) ins(16'(100 + i), 13'(i));
        chk("count_5", 32'(count), 32'd5);
        rst = 1'b1; ins_valid = 1'b1; ins_ftime = 16'd1; deq_req = 1'b1;
        tick();
        rst = 1'b0; ins_valid = 1'b0; deq_req = 1'b0;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_deq_valid", 32'(deq_valid), 32'd0);
        chk("midrst_ins_drop", 32'(ins_drop), 32'd0);

        begin
            int budget;
            budget = 20;
            while (exp_q.size() != 0 && budget > 0) begin
                tick();
                budget--;
            end
            chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wfq_tag_sorter.md
WFQ_TAG_SORTER -- requirements
Module: wfq_tag_sorter

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the finish-time tag width; flow_id width is N-3.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of tag slots (2..32).
REQ-003 clk  input  1  single clock, all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ins_valid  input  1  insert strobe, driven by the finish-time stage's done_ftime.
REQ-006 ins_ftime  input  N  finish-time tag to insert.
REQ-007 ins_flow_id  input  N-3  flow owning the tag.
REQ-008 deq_req  input  1  request to pop the smallest tag.
REQ-009 deq_valid  output  1  one-cycle pulse: deq_ftime/deq_flow_id hold the popped entry.
REQ-010 deq_ftime  output  N  popped tag.
REQ-011 deq_flow_id  output  N-3  popped flow.
REQ-012 count  output  $clog2(DEPTH+1)  number of occupied slots.
REQ-013 empty  output  1  count==0.
REQ-014 full  output  1  count==DEPTH.
REQ-015 ins_drop  output  1  one-cycle pulse: an insert was rejected.

Function
REQ-016 Storage SHALL be DEPTH slots of {ftime, flow_id, valid}, kept sorted ascending from slot 0 (head) every cycle.
REQ-017 Insert SHALL place the new entry after every stored entry whose tag is less than or equal to it (FIFO order among equal tags), shifting later entries one slot toward the tail, in a single cycle.
REQ-018 Dequeue SHALL occur when deq_req=1 and count>0: slot 0 is removed and the remaining entries shift one slot toward the head.
REQ-019 Dequeue latency SHALL be 1 cycle: deq_req sampled at edge t produces deq_valid=1 with the head values after edge t; deq_ftime/deq_flow_id hold their last values when deq_valid=0.
REQ-020 deq_req with count==0 SHALL be ignored: deq_valid stays 0, no state change.
REQ-021 Insert and dequeue in the same cycle with count>0 SHALL both take effect: the old head is popped; the new entry is sorted into the remaining entries; count is unchanged.
REQ-022 Insert and dequeue in the same cycle with count==0 SHALL accept the insert only; there is no bypass, and deq_valid stays 0.
REQ-023 An insert with full=1 and no simultaneous dequeue SHALL be discarded with ins_drop=1 on the following cycle; an insert with full=1 and a simultaneous dequeue SHALL be accepted.
REQ-024 Inserts SHALL be accepted on back-to-back cycles at full rate.
REQ-025 count, empty and full SHALL be registered and SHALL reflect the state after the current edge.

Reset
REQ-026 rst=1 SHALL clear every slot valid bit and set count=0, empty=1, full=0, deq_valid=0, ins_drop=0, deq_ftime=0 and deq_flow_id=0.
REQ-027 rst SHALL override any insert or dequeue in the same cycle, including one issued mid-operation; stored entries are lost and no deq_valid is produced for that cycle.

Configuration
REQ-028 With WFQ_TAG_WRAP_CMP_EN defined, tag a SHALL order before tag b when bit N-1 of (a-b) mod 2^N is 1 (serial-number compare), so finish times that wrap past 2^N-1 still sort correctly within a half-range window.
REQ-029 Without WFQ_TAG_WRAP_CMP_EN, tags SHALL be compared as plain unsigned N-bit values.

Verification
REQ-030 Reset, then insert tags 40/f1, 10/f2, 25/f3, then issue 3 deq_req -> deq outputs are 10/f2, 25/f3, 40/f1, each deq_valid 1 cycle after its request, then empty=1.
REQ-031 Insert 20/f1 then 20/f5, then dequeue twice -> output order f1 then f5.
REQ-032 DEPTH=8: fill with 8 tags, then insert a 9th -> ins_drop pulses, count=8; then insert 5 together with deq_req -> the old head pops, tag 5 becomes the head, count stays 8.
REQ-033 With count=0, assert deq_req together with an insert of 7 -> deq_valid=0, count=1; the next deq_req returns 7.
REQ-034 With the macro defined and N=16, insert 0xFFF0 then 0x0010 -> dequeue order 0xFFF0, 0x0010; without the macro -> order 0x0010, 0xFFF0.
REQ-035 Fill 5 entries, assert rst together with an insert and a deq_req -> the cycle after: count=0, empty=1, deq_valid=0, ins_drop=0.
